ex_muldiv_unit: RTL and testbench

Execute-stage multiply/divide unit. It sits on the output side of the ID/EX pipeline register and consumes the registered operands and `funct` field for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It owns the architectural HI/LO registers and runs 32-iteration shift-add multiply and restoring divide in the background. It drives a stall interlock back to IF/ID/ID_EX when a dependent instruction reaches EX while an operation is in flight.

---
 rtl/ex_muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs 32-step shift-add multiply
// and restoring divide in the background, and interlocks dependent instructions.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       fsmState
);

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  logic [1:0]         state;
  logic [4:0]         cnt;
  logic [WIDTH-1:0]   magA, magB;
  logic               aNegR, bNegR, opDiv;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem, quo;

  logic               isMd, accept, opSigned, aNeg, bNeg;
  logic [WIDTH-1:0]   magAIn, magBIn;
  logic [WIDTH:0]     mulSum, divShifted;
  logic               divBorrow, negRes;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  always_comb begin
    isMd = 1'b0;
    case (funct)
      FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: isMd = 1'b1;
      default: isMd = 1'b0;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign stall    = issue & isMd & busy;
  assign accept   = issue & isMd & ~busy;
  assign fsmState = state;

  // MFHI/MFLO complete combinationally in the cycle they are accepted.
  assign result_valid = accept & ((funct == FN_MFHI) | (funct == FN_MFLO));
  assign result       = !result_valid ? '0 : ((funct == FN_MFHI) ? hi : lo);

  assign opSigned = (funct == FN_MULT) | (funct == FN_DIV);
  assign aNeg     = opSigned & readData1[WIDTH-1];
  assign bNeg     = opSigned & readData2[WIDTH-1];
  assign magAIn   = aNeg ? -readData1 : readData1;
  assign magBIn   = bNeg ? -readData2 : readData2;

  // Multiply: {upper, multiplier} shifts right, adding magA when the LSB is set.
  assign mulSum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, magA} : '0);

  // Divide: 33-bit trial remainder; a fitting subtraction always fits in WIDTH bits.
  assign divShifted = {rem, quo[WIDTH-1]};
  assign divBorrow  = divShifted < {1'b0, magB};

  assign negRes  = aNegR ^ bNegR;
  assign prodFix = negRes ? -prod : prod;
  assign quoFix  = negRes ? -quo : quo;
  assign remFix  = aNegR ? -rem : rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      magA  <= '0;
      magB  <= '0;
      aNegR <= 1'b0;
      bNegR <= 1'b0;
      opDiv <= 1'b0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (funct)
              FN_MTHI: hi <= readData1;
              FN_MTLO: lo <= readData1;
              FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                magA  <= magAIn;
                magB  <= magBIn;
                aNegR <= aNeg;
                bNegR <= bNeg;
                cnt   <= '0;
                opDiv <= funct[1];
                prod  <= {{WIDTH{1'b0}}, magBIn};
                rem   <= '0;
                quo   <= magAIn;
                state <= funct[1] ? S_DIV : S_MUL;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          prod <= {mulSum, prod[WIDTH-1:1]};
          cnt  <= cnt + 5'd1;
          if (cnt == LAST_STEP) state <= S_FIX;
        end
        S_DIV: begin
          rem <= divBorrow ? divShifted[WIDTH-1:0] : divShifted[WIDTH-1:0] - magB;
          quo <= {quo[WIDTH-2:0], ~divBorrow};
          cnt <= cnt + 5'd1;
          if (cnt == LAST_STEP) state <= S_FIX;
        end
        default: begin
          // A zero divisor leaves the dividend magnitude in rem; its sign fixup restores the dividend.
          if (opDiv) begin
            hi <= remFix;
            lo <= (magB == '0) ? '1 : quoFix;
          end else begin
            {hi, lo} <= prodFix;
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: arithmetic reference model checked every cycle plus
// directed vectors with hand-computed HI/LO values.
module tb_ex_muldiv_unit;

  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
  localparam int LATENCY = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue;
  logic [5:0]  funct;
  logic [31:0] readData1, readData2;
  logic        stall, busy, result_valid;
  logic [31:0] hi, lo, result;
  logic [1:0]  fsmState;

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  logic [31:0] mHi, mLo;
  int          mCnt;
  bit          modelLive = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .funct(funct),
    .readData1(readData1), .readData2(readData2),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo),
    .result(result), .result_valid(result_valid), .fsmState(fsmState)
  );

  function automatic bit recog(input logic [5:0] f);
    case (f)
      MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Returns {HI, LO} for a multiply/divide, from plain arithmetic.
  function automatic logic [63:0] refOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      MULT:  return sa * sb;
      MULTU: return ua * ub;
      DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [63:0] r;
    if (!rst_n) begin
      mHi <= '0;
      mLo <= '0;
      mCnt <= 0;
      exp_q.delete();
    end else if (mCnt > 0) begin
      mCnt <= mCnt - 1;
      if (mCnt == 1) begin
        r = exp_q.pop_front();
        mHi <= r[63:32];
        mLo <= r[31:0];
      end
    end else if (issue && recog(funct)) begin
      case (funct)
        MTHI: mHi <= readData1;
        MTLO: mLo <= readData1;
        MULT, MULTU, DIV, DIVU: begin
          exp_q.push_back(refOp(funct, readData1, readData2));
          mCnt <= LATENCY;
        end
        default: ;
      endcase
    end
    modelLive <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic expRv;
    if (modelLive) begin
      expRv = issue && (funct == MFHI || funct == MFLO) && (mCnt == 0);
      check("busy", 32'(busy), 32'(mCnt > 0));
      check("stall", 32'(stall), 32'(issue && recog(funct) && (mCnt > 0)));
      check("hi", hi, mHi);
      check("lo", lo, mLo);
      check("result_valid", 32'(result_valid), 32'(expRv));
      check("result", result, expRv ? ((funct == MFHI) ? mHi : mLo) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issueOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    issue = 1'b1;
    funct = f;
    readData1 = a;
    readData2 = b;
    tick();
    issue = 1'b0;
    funct = 6'($urandom);
    readData1 = $urandom;
    readData2 = $urandom;
  endtask

  task automatic runOp(input string name, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
    int n;
    issueOp(f, a, b);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(LATENCY));
    check({name, "_hi"}, hi, expHi);
    check({name, "_lo"}, lo, expLo);
  endtask

  initial begin : stimulus
    int n;
    rst_n = 1'b0;
    issue = 1'b0;
    funct = '0;
    readData1 = '0;
    readData2 = '0;
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      issue = 1'($urandom_range(0, 1));
      funct = 6'($urandom_range(16, 27));
      readData1 = $urandom;
      readData2 = $urandom;
      tick();
    end
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_valid", 32'(result_valid & ~issue), 32'd0);
    rst_n = 1'b1;
    issue = 1'b0;
    tick();

    runOp("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    runOp("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    runOp("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div_negb",  DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);
    runOp("divu",      DIVU,  32'd100,       32'd7,        32'd2,        32'd14);
    runOp("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
    runOp("divu_zero", DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF);
    runOp("div_zero",  DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MFLO held behind a running MULT
    issueOp(MULT, 32'd6, 32'd7);
    issue = 1'b1;
    funct = MFLO;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    check("mflo_stall_cycles", 32'(n), 32'(LATENCY));
    check("mflo_result", result, 32'd42);
    check("mflo_valid", 32'(result_valid), 32'd1);
    tick();
    issue = 1'b0;

    // Independent instruction overlapping a multiply never stalls
    issueOp(MULT, 32'd3, 32'd5);
    issue = 1'b1;
    funct = 6'h20;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("nonmd_stall", 32'(stall), 32'd0);
      tick();
    end
    issue = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check("overlap_lo", lo, 32'd15);
    check("overlap_hi", hi, 32'd0);

    // Moves and MFHI
    issueOp(MTHI, 32'hDEAD_BEEF, 32'd0);
    check("mthi", hi, 32'hDEAD_BEEF);
    issueOp(MTLO, 32'h0BAD_F00D, 32'd0);
    check("mtlo", lo, 32'h0BAD_F00D);
    issue = 1'b1;
    funct = MFHI;
    #1;
    check("mfhi_result", result, 32'hDEAD_BEEF);
    check("mfhi_valid", 32'(result_valid), 32'd1);
    tick();
    issue = 1'b0;

    // Reset during a divide aborts it with no late write
    issueOp(DIV, 32'd1000, 32'd3);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    rst_n = 1'b1;
    repeat (40) tick();
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);
    check("abort_late_busy", 32'(busy), 32'd0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    nMismatched++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $fatal(1, "watchdog expired");
  end

endmodule
